// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch stage.
//   XLEN        : address / PC width
//   ILEN        : instruction width
//   INSTR_BYTES : bytes per fetched instruction word (fetch PC stride)
//   fetch_entry_t : one fetch-buffer slot {pc, instr, filled}
package fetch_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Fetch stage between PC/branch-target logic and decode. Keeps its own
//   fetch PC, issues in-order word requests to instruction memory, buffers
//   up to DEPTH returned instructions tagged with their PC and hands them to
//   decode in order. A redirect flushes the buffer, arranges for responses
//   still in flight to be discarded, and restarts fetch at the target.
//
//   Parameters : DEPTH (buffer entries, power of two, >= 2), RESET_PC.
//                XLEN / ILEN come from fetch_pkg.
//   Ports      :
//     clk, rst                    clock (rising edge), async active-high reset
//     redirect_valid/redirect_pc  flush and restart fetch (pc bits [1:0] ignored)
//     imem_req_valid/ready/addr   request channel to instruction memory
//     imem_rsp_valid/data         in-order response channel (no back-pressure)
//     out_valid/ready/pc/instr    head instruction to decode
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  fetch_entry_t    entries_q [DEPTH];
  fetch_entry_t    entries_d [DEPTH];
  logic [PW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]   head_ptr_q, head_ptr_d;
  logic [PW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [ILEN-1:0] hold_instr_q, hold_instr_d;

  logic [PW-1:0]   allocated;
  logic [PW-1:0]   outstanding;
  logic [AW-1:0]   head_idx, fill_idx, alloc_idx;
  fetch_entry_t    head;
  logic            req_fire, rsp_keep, rsp_drop, pop_fire;

  // Pointers carry a wrap bit, so plain subtraction gives occupancy 0..DEPTH.
  assign allocated   = alloc_ptr_q - head_ptr_q;
  assign outstanding = alloc_ptr_q - fill_ptr_q;
  assign head_idx    = head_ptr_q[AW-1:0];
  assign fill_idx    = fill_ptr_q[AW-1:0];
  assign alloc_idx   = alloc_ptr_q[AW-1:0];
  assign head        = entries_q[head_idx];

  // Requests stay off while stale responses are still owed to us, so a
  // dropped response can never be mistaken for a fresh one.
  assign imem_req_valid = (allocated < DEPTH_P) && (drop_cnt_q == '0) &&
                          !redirect_valid && !rst;
  assign imem_req_addr  = fetch_pc_q;

  assign out_valid = (allocated != '0) && head.filled && !redirect_valid;
  // When nothing is presented, the last presented instruction stays visible.
  assign out_pc    = out_valid ? head.pc    : hold_pc_q;
  assign out_instr = out_valid ? head.instr : hold_instr_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0);
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign pop_fire = out_valid && out_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    entries_d    = entries_q;
    alloc_ptr_d  = alloc_ptr_q;
    fill_ptr_d   = fill_ptr_q;
    head_ptr_d   = head_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    if (out_valid) begin
      hold_pc_d    = head.pc;
      hold_instr_d = head.instr;
    end

    if (redirect_valid) begin
      // Every request not yet answered will still be answered; those answers
      // (plus any already owed) must be thrown away before fetch resumes.
      fetch_pc_d  = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].filled = 1'b0;
      end
      drop_cnt_d = outstanding - PW'(rsp_keep) + (drop_cnt_q - PW'(rsp_drop));
    end else begin
      // Pop, response and request touch distinct slots, so all three may
      // take effect in the same cycle.
      if (pop_fire) begin
        entries_d[head_idx].filled = 1'b0;
        head_ptr_d = head_ptr_q + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - PW'(1);
      end
      if (rsp_keep) begin
        entries_d[fill_idx].instr  = imem_rsp_data;
        entries_d[fill_idx].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (req_fire) begin
        entries_d[alloc_idx].pc     = fetch_pc_q;
        entries_d[alloc_idx].filled = 1'b0;
        alloc_ptr_d = alloc_ptr_q + PW'(1);
        fetch_pc_d  = fetch_pc_q + XLEN'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      alloc_ptr_q  <= '0;
      fill_ptr_q   <= '0;
      head_ptr_q   <= '0;
      drop_cnt_q   <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      alloc_ptr_q  <= alloc_ptr_d;
      fill_ptr_q   <= fill_ptr_d;
      head_ptr_q   <= head_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      entries_q    <= entries_d;
    end
  end

  // Memory must never answer a request we did not make.
  a_no_spurious_rsp : assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> ((outstanding != '0) || (drop_cnt_q != '0)));

  a_alloc_bound : assert property (@(posedge clk) disable iff (rst)
    allocated <= DEPTH_P);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer
//   Directed + randomised bench for instr_fetch_buffer. A memory model
//   answers every request in order after a configurable latency; a
//   scoreboard queue holds the {pc, instr} decode should see next.
module tb_instr_fetch_buffer;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  logic [63:0] req_log[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_due   = 0;
  int n_req      = 0;
  int n_pop      = 0;
  int lat_min    = 1;
  int lat_max    = 1;
  int base;
  int redir_cyc;
  int resume_cyc;

  logic [63:0] exp_fetch  = RESET_PC;
  logic [63:0] hold_pc    = '0;
  logic [31:0] hold_instr = '0;
  logic        tb_rst          = 1'b1;
  logic        tb_redirect     = 1'b0;
  logic [63:0] tb_redirect_pc  = '0;
  logic        tb_out_ready    = 1'b0;
  logic        rand_ready      = 1'b0;
  logic        rand_out_ready  = 1'b0;
  logic        req_fire        = 1'b0;
  logic        pop_fire        = 1'b0;
  logic [63:0] req_addr_s      = '0;
  logic        await_first     = 1'b0;
  logic [63:0] first_pop_pc    = '1;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    exp_q.delete();
    rsp_q.delete();
    last_due    = 0;
    exp_fetch   = RESET_PC;
    hold_pc     = '0;
    hold_instr  = '0;
    await_first = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, then observe what
  // the coming rising edge will do and update the models accordingly.
  task automatic applyStimulus();
    int lat;
    int due;
    exp_t e;
    rsp_t r;
    @(negedge clk);
    cyc++;
    rst            = tb_rst;
    redirect_valid = tb_redirect;
    redirect_pc    = tb_redirect_pc;
    out_ready      = rand_out_ready ? ($urandom_range(0, 1) == 1) : tb_out_ready;
    imem_req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = rsp_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    req_fire   = imem_req_valid && imem_req_ready;
    pop_fire   = out_valid && out_ready;
    req_addr_s = imem_req_addr;

    if (out_valid) begin
      checkOutput("exp_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        checkOutput("out_pc", out_pc, exp_q[0].pc);
        checkOutput("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        hold_pc    = exp_q[0].pc;
        hold_instr = exp_q[0].instr;
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
          if (await_first) begin
            first_pop_pc = out_pc;
            await_first  = 1'b0;
          end
        end
      end
    end else begin
      checkOutput("hold_pc", out_pc, hold_pc);
      checkOutput("hold_instr", 64'(out_instr), 64'(hold_instr));
    end

    if (imem_rsp_valid) void'(rsp_q.pop_front());

    if (req_fire) begin
      checkOutput("req_addr", imem_req_addr, exp_fetch);
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due  = due;
      r.data = mem_word(imem_req_addr);
      rsp_q.push_back(r);
      e.pc    = exp_fetch;
      e.instr = mem_word(exp_fetch);
      exp_q.push_back(e);
      req_log.push_back(imem_req_addr);
      exp_fetch = exp_fetch + 64'd4;
      n_req++;
    end

    if (redirect_valid) begin
      checkOutput("redir_out_valid", 64'(out_valid), 64'd0);
      checkOutput("redir_req_valid", 64'(imem_req_valid), 64'd0);
      exp_q.delete();
      exp_fetch   = {redirect_pc[63:2], 2'b00};
      await_first = 1'b1;
    end
  endtask

  task automatic doReset();
    tb_rst = 1'b1;
    clearModel();
    repeat (2) applyStimulus();
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_pc", out_pc, 64'd0);
    checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
    tb_rst = 1'b0;
  endtask

  initial begin
    // Streaming: always-ready memory, 1-cycle latency, decode always ready.
    lat_min = 1; lat_max = 1; tb_out_ready = 1'b1;
    doReset();
    applyStimulus();
    checkOutput("t1_req0_fire", 64'(req_fire), 64'd1);
    checkOutput("t1_req0_addr", req_addr_s, 64'h0);
    checkOutput("t1_c0_valid", 64'(out_valid), 64'd0);
    applyStimulus();
    checkOutput("t1_req1_addr", req_addr_s, 64'h4);
    checkOutput("t1_c1_valid", 64'(out_valid), 64'd0);
    applyStimulus();
    checkOutput("t1_req2_addr", req_addr_s, 64'h8);
    checkOutput("t1_first_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_first_pc", out_pc, 64'h0);
    base = n_pop;
    repeat (10) applyStimulus();
    checkOutput("t1_steady_pops", 64'(n_pop - base), 64'd10);

    // Full buffer: decode stalled, exactly DEPTH requests then stop.
    tb_out_ready = 1'b0;
    doReset();
    base = n_req;
    repeat (8) applyStimulus();
    checkOutput("t2_full_reqs", 64'(n_req - base), 64'd4);
    checkOutput("t2_full_req_valid", 64'(imem_req_valid), 64'd0);
    tb_out_ready = 1'b1;
    applyStimulus();
    checkOutput("t2_pop", 64'(pop_fire), 64'd1);
    tb_out_ready = 1'b0;
    applyStimulus();
    checkOutput("t2_resume_fire", 64'(req_fire), 64'd1);
    checkOutput("t2_resume_addr", req_addr_s, 64'h10);
    applyStimulus();
    checkOutput("t2_full_again", 64'(imem_req_valid), 64'd0);

    // Redirect with two requests outstanding (4-cycle latency).
    lat_min = 4; lat_max = 4; tb_out_ready = 1'b1;
    doReset();
    repeat (2) applyStimulus();
    tb_redirect = 1'b1; tb_redirect_pc = 64'h1003;
    applyStimulus();
    redir_cyc = cyc;
    tb_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus();
      if (req_fire) begin
        found = 1'b1;
        resume_cyc = cyc;
      end
    end
    checkOutput("t3_resume_found", 64'(found), 64'd1);
    if (found) begin
      checkOutput("t3_resume_delay", 64'(resume_cyc - redir_cyc), 64'd4);
      checkOutput("t3_resume_addr", req_addr_s, 64'h1000);
    end
    repeat (12) applyStimulus();
    checkOutput("t3_first_pc", first_pop_pc, 64'h1000);

    // Redirect in the cycle pc 0x8 would have been popped.
    lat_min = 1; lat_max = 1; tb_out_ready = 1'b1;
    doReset();
    repeat (4) applyStimulus();
    first_pop_pc = '1;
    tb_redirect = 1'b1; tb_redirect_pc = 64'h2000;
    applyStimulus();
    tb_redirect = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("t4_first_pc", first_pop_pc, 64'h2000);

    // Randomised traffic with occasional redirects.
    lat_min = 1; lat_max = 5;
    rand_ready = 1'b1; rand_out_ready = 1'b1;
    doReset();
    base = n_pop;
    for (int i = 0; i < 10000; i++) begin
      tb_redirect = ($urandom_range(0, 149) == 0);
      tb_redirect_pc = {$urandom(), $urandom()};
      applyStimulus();
    end
    tb_redirect = 1'b0;
    checkOutput("t5_progress", 64'(n_pop - base > 1000), 64'd1);
    rand_ready = 1'b0; rand_out_ready = 1'b0;

    // Fetch PC wrap, then asynchronous reset mid-burst.
    lat_min = 2; lat_max = 2; tb_out_ready = 1'b1;
    doReset();
    repeat (2) applyStimulus();
    tb_redirect = 1'b1; tb_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    applyStimulus();
    tb_redirect = 1'b0;
    req_log.delete();
    for (int i = 0; i < 10 && req_log.size() < 2; i++) applyStimulus();
    checkOutput("t6_two_reqs", 64'(req_log.size() >= 2), 64'd1);
    if (req_log.size() >= 2) begin
      checkOutput("t6_addr_top", req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
      checkOutput("t6_addr_wrap", req_log[1], 64'h0);
    end
    repeat (3) applyStimulus();
    @(posedge clk);
    #2;
    rst = 1'b1;
    tb_rst = 1'b1;
    #1;
    checkOutput("t6_async_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("t6_async_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_async_out_pc", out_pc, 64'd0);
    checkOutput("t6_async_out_instr", 64'(out_instr), 64'd0);
    checkOutput("t6_async_req_addr", imem_req_addr, RESET_PC);
    clearModel();
    @(posedge clk);
    #1;
    checkOutput("t6_edge_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_edge_out_pc", out_pc, 64'd0);
    repeat (2) applyStimulus();
    tb_rst = 1'b0;
    applyStimulus();
    checkOutput("t6_first_req", 64'(req_fire), 64'd1);
    checkOutput("t6_first_addr", req_addr_s, RESET_PC);
    repeat (4) applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
